// File: rtl/uart_ascii_printer.sv
// uart_ascii_printer
// Free-running 8N1 UART transmitter that cycles through the printable ASCII
// range (FIRST_CHAR..LAST_CHAR) while TX_Enable is held high. Exports the
// character in flight for a display decoder and pulses Frame_Done on the
// last cycle of every stop bit.
// Optional feature: define UART_ASCII_PRINTER_CRLF_EN to append a CR (0x0D)
// and LF (0x0A) frame after LAST_CHAR before wrapping to FIRST_CHAR.
module uart_ascii_printer #(
    parameter int          CLKS_PER_BIT = 10416,
    parameter logic [7:0]  FIRST_CHAR   = 8'h20,
    parameter logic [7:0]  LAST_CHAR    = 8'h7E
) (
    input  logic       Clock_100MHz,
    input  logic       Reset_n,
    input  logic       TX_Enable,
    output logic       RXD,
    output logic       Busy,
    output logic [7:0] Current_Char,
    output logic       Frame_Done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Two-flop synchronizer for the asynchronous enable request
    logic              en_meta_reg;
    logic              en_s_reg;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic [7:0]        char_reg, char_next;
    logic              rxd_reg, rxd_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    // Character that follows char_reg in the printed sequence
    logic [7:0]        adv_char;
    logic              baud_done;

    assign baud_done = (baud_cnt_reg == BAUD_LAST);

`ifdef UART_ASCII_PRINTER_CRLF_EN
    // Tracks whether the frame in flight is the appended CR or LF, so the
    // end-of-line frames are recognised independently of the character range.
    typedef enum logic [1:0] {
        CRLF_NONE = 2'd0,
        CRLF_CR   = 2'd1,
        CRLF_LF   = 2'd2
    } crlf_t;

    crlf_t crlf_reg, crlf_next, adv_crlf;

    // Sequence step: LAST_CHAR -> CR -> LF -> FIRST_CHAR
    always_comb begin
        adv_char = char_reg + 8'd1;
        adv_crlf = CRLF_NONE;
        if (crlf_reg == CRLF_CR) begin
            adv_char = 8'h0A;
            adv_crlf = CRLF_LF;
        end else if (crlf_reg == CRLF_LF) begin
            adv_char = FIRST_CHAR;
            adv_crlf = CRLF_NONE;
        end else if (char_reg == LAST_CHAR) begin
            adv_char = 8'h0D;
            adv_crlf = CRLF_CR;
        end
    end
`else
    // Sequence step: LAST_CHAR wraps straight to FIRST_CHAR
    always_comb begin
        adv_char = (char_reg == LAST_CHAR) ? FIRST_CHAR : (char_reg + 8'd1);
    end
`endif

    // Synchronize TX_Enable into the clock domain
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            en_meta_reg <= 1'b0;
            en_s_reg    <= 1'b0;
        end else begin
            en_meta_reg <= TX_Enable;
            en_s_reg    <= en_meta_reg;
        end
    end

    // Next-state, counters, shifter and registered-output precomputation
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        char_next     = char_reg;
`ifdef UART_ASCII_PRINTER_CRLF_EN
        crlf_next     = crlf_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (en_s_reg) begin
                    shift_next    = char_reg;
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    shift_next    = {1'b0, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    // Frame boundary: the only point where the character moves
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    char_next     = adv_char;
`ifdef UART_ASCII_PRINTER_CRLF_EN
                    crlf_next     = adv_crlf;
`endif
                    if (en_s_reg) begin
                        shift_next = adv_char;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are derived from the next state so they land in registers
        case (state_next)
            START:   rxd_next = 1'b0;
            DATA:    rxd_next = shift_next[0];
            default: rxd_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == STOP) && (baud_cnt_next == BAUD_LAST);
    end

    // State, datapath and output registers
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            char_reg     <= FIRST_CHAR;
            rxd_reg      <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            char_reg     <= char_next;
            rxd_reg      <= rxd_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

`ifdef UART_ASCII_PRINTER_CRLF_EN
    // End-of-line phase register
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            crlf_reg <= CRLF_NONE;
        end else begin
            crlf_reg <= crlf_next;
        end
    end
`endif

    assign RXD          = rxd_reg;
    assign Busy         = busy_reg;
    assign Current_Char = char_reg;
    assign Frame_Done   = done_reg;

endmodule

// File: tb/tb_uart_ascii_printer.sv
// Directed self-checking bench for uart_ascii_printer at CLKS_PER_BIT=4.
module tb_uart_ascii_printer;

    logic       clk;
    logic       Reset_n;
    logic       TX_Enable;
    logic       RXD;
    logic       Busy;
    logic [7:0] Current_Char;
    logic       Frame_Done;

    int checks   = 0;
    int failures = 0;
    int done_count = 0;
    int bad_idle_count = 0;

    uart_ascii_printer #(
        .CLKS_PER_BIT(4),
        .FIRST_CHAR  (8'h20),
        .LAST_CHAR   (8'h7E)
    ) dut (
        .Clock_100MHz(clk),
        .Reset_n     (Reset_n),
        .TX_Enable   (TX_Enable),
        .RXD         (RXD),
        .Busy        (Busy),
        .Current_Char(Current_Char),
        .Frame_Done  (Frame_Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count Frame_Done pulses and any cycle where the line is not idle
    always @(negedge clk) begin
        if (Frame_Done === 1'b1) done_count <= done_count + 1;
        if (RXD !== 1'b1 || Busy !== 1'b0) bad_idle_count <= bad_idle_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a start bit, capture 40 cycles and compare the
    // line, Busy, Frame_Done and Current_Char against an ideal frame.
    task automatic check_frame(input logic [7:0] exp_char, input int max_wait,
                               input int drop_at, output int waited);
        logic [39:0] wave, busy_v, done_v, exp_wave;
        logic [9:0]  bits;
        logic        char_ok;
        waited  = 0;
        char_ok = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (RXD !== 1'b0 && waited < max_wait);
        check($sformatf("start_%02h", exp_char), 64'(RXD), 64'(0));
        if (RXD !== 1'b0) return;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (i == drop_at) TX_Enable = 1'b0;
            wave[i]   = RXD;
            busy_v[i] = Busy;
            done_v[i] = Frame_Done;
            if (Current_Char !== exp_char) char_ok = 1'b0;
        end
        bits = {1'b1, exp_char, 1'b0};
        for (int i = 0; i < 40; i++) exp_wave[i] = bits[i / 4];
        check($sformatf("wave_%02h", exp_char), 64'(wave), 64'(exp_wave));
        check($sformatf("busy_%02h", exp_char), 64'(busy_v), 64'(40'hFF_FFFF_FFFF));
        check($sformatf("done_%02h", exp_char), 64'(done_v), 64'(40'h80_0000_0000));
        check($sformatf("char_%02h", exp_char), 64'(char_ok), 64'(1));
        $display("frame char=%02h wave=%010h wait=%0d", exp_char, wave, waited);
    endtask

    initial begin
        int w;
        int d0;
        int b0;
        Reset_n   = 1'b1;
        TX_Enable = 1'b0;
        #1 Reset_n = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        check("rst_rxd",  64'(RXD), 64'(1));
        check("rst_busy", 64'(Busy), 64'(0));
        check("rst_char", 64'(Current_Char), 64'(8'h20));
        check("rst_done", 64'(Frame_Done), 64'(0));
        Reset_n = 1'b1;
        repeat (100) @(negedge clk);
        @(posedge clk); #1;
        check("idle_done_count", 64'(done_count), 64'(0));
        check("idle_line", 64'(bad_idle_count), 64'(0));
        check("idle_char", 64'(Current_Char), 64'(8'h20));
        $display("idle 100 cycles char=%02h", Current_Char);

        // Single frame from a one-cycle enable pulse
        @(negedge clk);
        d0 = done_count;
        TX_Enable = 1'b1;
        @(negedge clk);
        TX_Enable = 1'b0;
        check_frame(8'h20, 4, -1, w);
        check("single_latency", 64'(w), 64'(2));
        @(posedge clk); #1;
        check("single_done_count", 64'(done_count), 64'(d0 + 1));
        check("single_busy", 64'(Busy), 64'(0));
        check("single_char", 64'(Current_Char), 64'(8'h21));
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        check("single_no_more", 64'(done_count), 64'(d0 + 1));
        check("single_rxd", 64'(RXD), 64'(1));

        // Reset, then continuous run through the wrap
        @(negedge clk);
        Reset_n = 1'b0;
        repeat (3) @(negedge clk);
        Reset_n = 1'b1;
        check("rerst_char", 64'(Current_Char), 64'(8'h20));
        @(negedge clk);
        TX_Enable = 1'b1;
        check_frame(8'h20, 4, -1, w);
        check("run_latency", 64'(w), 64'(3));
        for (int c = 8'h21; c <= 8'h7E; c++) check_frame(8'(c), 1, -1, w);
`ifdef UART_ASCII_PRINTER_CRLF_EN
        check_frame(8'h0D, 1, -1, w);
        check_frame(8'h0A, 1, -1, w);
`endif
        for (int c = 8'h20; c <= 8'h40; c++) check_frame(8'(c), 1, -1, w);

        // Mid-frame deassert during data bit 3 of 0x41
        check_frame(8'h41, 1, 17, w);
        @(posedge clk); #1;
        check("drop_busy", 64'(Busy), 64'(0));
        check("drop_char", 64'(Current_Char), 64'(8'h42));
        check("drop_rxd", 64'(RXD), 64'(1));
        b0 = bad_idle_count;
        repeat (50) @(negedge clk);
        @(posedge clk); #1;
        check("drop_stays_idle", 64'(bad_idle_count), 64'(b0));

        // Reset asserted in the middle of the DATA state
        @(negedge clk);
        TX_Enable = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (RXD !== 1'b0 && w < 10);
        check("mid_start_seen", 64'(RXD), 64'(0));
        repeat (10) @(negedge clk);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_rxd",  64'(RXD), 64'(1));
        check("mid_rst_busy", 64'(Busy), 64'(0));
        check("mid_rst_char", 64'(Current_Char), 64'(8'h20));
        TX_Enable = 1'b0;
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);
        TX_Enable = 1'b1;
        check_frame(8'h20, 6, -1, w);
        check("mid_re_latency", 64'(w), 64'(3));
        TX_Enable = 1'b0;
        repeat (60) @(negedge clk);
        check("end_busy", 64'(Busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_ascii_printer.md
# uart_ascii_printer

Free-running UART transmit source that prints the printable ASCII set (0x20 ' ' through 0x7E '~') over the serial line while TX_Enable is held high. It runs directly on Clock_100MHz with an internal baud counter, drives the board's RXD line toward the host terminal, and exports the character currently being sent so the 7-segment decoder can display it. It is the upstream stage of the host link and of the display path.

## Interface
- CLKS_PER_BIT, 10416, Clock_100MHz cycles per serial bit (9600 baud); legal range ≥ 2
- FIRST_CHAR, 8'h20, first character of the sequence and wrap target
- LAST_CHAR, 8'h7E, last character before wrap; FIRST_CHAR ≤ LAST_CHAR
- Clock_100MHz  input  1  system clock; all logic on its rising edge
- Reset_n  input  1  asynchronous, active-low reset
- TX_Enable  input  1  asynchronous level request; printing runs while high
- RXD  output  1  serial line: 8N1, LSB first, idle high
- Busy  output  1  high while a frame (start, data, or stop bit) is on RXD
- Current_Char  output  8  character of the frame in progress; in IDLE, the next character to send
- Frame_Done  output  1  one-cycle pulse on the last cycle of each stop bit

## Operation
- TX_Enable passes through a 2-flop synchronizer (en_s). Decisions use en_s only.
- States: IDLE, START, DATA, STOP.
- IDLE: RXD=1, Busy=0. If en_s=1: latch Current_Char into the shift register, clear baud and bit counters, go to START.
- START: RXD=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: RXD = shift[0]. Each bit holds CLKS_PER_BIT cycles. After 8 bits, go to STOP.
- STOP: RXD=1 for CLKS_PER_BIT cycles. Frame_Done=1 on the final cycle. On that edge, advance Current_Char: LAST_CHAR wraps to FIRST_CHAR, otherwise +1. Then:
  - if en_s=1, go to START with the new character (back-to-back, no idle gap);
  - otherwise go to IDLE.
- Deasserting TX_Enable mid-frame never truncates the frame. The frame completes, then the block goes to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide. The bit counter counts 0..7.
- Reset values: state=IDLE, RXD=1, Busy=0, Frame_Done=0, Current_Char=FIRST_CHAR, counters=0, synchronizer=0.
- Reset asserted mid-frame: RXD returns high immediately (asynchronously). The sequence restarts at FIRST_CHAR.

## Timing
- Latency from request to line: TX_Enable is high at rising edge E0. en_s goes high after E1. The block enters START at E2, so RXD falls after E2.
- Frame length: exactly 10×CLKS_PER_BIT cycles from RXD falling to the end of the stop bit.
- Back-to-back frames: the next start bit begins the cycle after the Frame_Done cycle.
- Busy rises with the entry to START and falls with the entry to IDLE.
- Current_Char changes only on the Frame_Done edge, and is stable for the whole frame.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: UART_ASCII_PRINTER_CRLF_EN.
- Defined: after the LAST_CHAR frame, send 0x0D and then 0x0A as two normal frames, then continue with FIRST_CHAR. Current_Char shows 0x0D and 0x0A during those frames. Each of the two frames still obeys the en_s check at STOP.
- Undefined: LAST_CHAR wraps directly to FIRST_CHAR. No CR or LF is ever sent.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset then idle: Reset_n low for 3 cycles, TX_Enable=0 for 100 cycles.
  - Required: RXD=1, Busy=0, Current_Char=0x20, Frame_Done never pulses.
- Single frame: pulse TX_Enable high for 1 cycle.
  - Required: after the 2-cycle sync, RXD carries exactly one frame, 0,0,0,0,0,0,1,0,0,1 (start bit, 0x20 LSB first, stop bit), each bit 4 cycles wide (40 cycles total).
  - Then: one Frame_Done pulse, Current_Char=0x21, return to IDLE.
- Continuous run and wrap: hold TX_Enable high for 95 frames.
  - Required: a serial monitor decodes 0x20..0x7E in order, then 0x20.
  - Required: no idle cycles between frames; frame spacing is exactly 40 cycles.
- Mid-frame deassert: drop TX_Enable during data bit 3 of the 0x41 frame.
  - Required: the 0x41 frame completes intact, then IDLE with Current_Char=0x42.
- Reset mid-frame: assert Reset_n low during the DATA state.
  - Required: RXD=1 within the same cycle, Busy=0, Current_Char=0x20.
  - Required: re-enabling sends 0x20 first.
- With UART_ASCII_PRINTER_CRLF_EN defined: run through the wrap.
  - Required: decoded sequence is …, 0x7D, 0x7E, 0x0D, 0x0A, 0x20.
